// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets one of NREQ requesters own
// a FIFO write port for a burst of up to BURST_MAX beats.
// A burst ends on req_last or when the beat count reaches the cap latched at
// grant time (1 when the FIFO is half full). Every grant is followed by one
// IDLE arbitration cycle.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  input  logic                     half_full,
  output logic [DATA_W-1:0]        data_write,
  output logic                     write_enable,
  output logic [NREQ-1:0]          grant,
  output logic                     busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]        r_state;
  logic [NREQ-1:0]   r_grant;
  logic [3:0]        r_cnt;
  logic [3:0]        r_cap;
  logic [IDX_W-1:0]  r_rrPtr;

  logic [IDX_W-1:0]  w_gIdx;
  logic [IDX_W-1:0]  w_selIdx;
  logic [NREQ-1:0]   w_selOneHot;
  logic              w_gValid;
  logic              w_gLast;
  logic [DATA_W-1:0] w_gData;
  logic              w_inBurst;
  logic              w_beat;
  logic [3:0]        w_cntNext;
  logic              w_end;

  // Turn the one-hot grant back into an index for muxing the owner's signals.
  always_comb begin
    w_gIdx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) w_gIdx = IDX_W'(i);
    end
  end

  // Pick the first valid requester starting just after the last owner.
  always_comb begin
    int  idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    w_selIdx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_rrPtr) + 1 + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        w_selIdx = IDX_W'(idx);
      end
    end
  end

  assign w_selOneHot = {{(NREQ-1){1'b0}}, 1'b1} << w_selIdx;

  assign w_inBurst = (r_state == BURST);
  assign w_gValid  = req_valid[w_gIdx];
  assign w_gLast   = req_last[w_gIdx];
  assign w_gData   = req_data[int'(w_gIdx)*DATA_W +: DATA_W];
  assign w_beat    = w_inBurst && w_gValid && !wfull;
  assign w_cntNext = r_cnt + 4'd1;
  assign w_end     = w_beat && (w_gLast || (w_cntNext == r_cap));

  assign req_ready    = (w_inBurst && !wfull) ? r_grant : '0;
  assign write_enable = w_beat;
  assign data_write   = w_inBurst ? w_gData : '0;
  assign grant        = r_grant;
  assign busy         = w_inBurst;

  // Arbitrate in IDLE, count beats in BURST, and hand priority on at burst end.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_cnt   <= 4'd0;
      r_cap   <= 4'(BURST_MAX);
      r_rrPtr <= IDX_W'(NREQ - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_grant <= w_selOneHot;
            r_cnt   <= 4'd0;
            r_cap   <= half_full ? 4'd1 : 4'(BURST_MAX);
            r_state <= BURST;
          end else begin
            r_grant <= '0;
          end
        end
        BURST: begin
          if (w_beat) begin
            r_cnt <= w_cntNext;
            if (w_end) begin
              r_state <= IDLE;
              r_grant <= '0;
              r_rrPtr <= w_gIdx;
              r_cnt   <= 4'd0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench for fifo_wr_arbiter.
// A small producer model offers numbered words per requester; every FIFO
// write the bench predicts is queued and matched against the DUT write port.
module tb_fifo_wr_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 8;

  logic                   wclk;
  logic                   wrst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic                   wfull;
  logic                   half_full;
  logic [DATA_W-1:0]      data_write;
  logic                   write_enable;
  logic [NREQ-1:0]        grant;
  logic                   busy;

  typedef struct packed {
    logic [NREQ-1:0]   grant;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t expQ[$];

  int checks   = 0;
  int failures = 0;

  logic [NREQ-1:0] active;
  int numWords[NREQ];
  int lastAt[NREQ];
  int wordIdx[NREQ];

  fifo_wr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .BURST_MAX(4)) dut (
    .wclk(wclk),
    .wrst_n(wrst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .wfull(wfull),
    .half_full(half_full),
    .data_write(data_write),
    .write_enable(write_enable),
    .grant(grant),
    .busy(busy)
  );

  // Free-running write clock, rising edges at 5, 15, 25 ...
  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  function automatic logic [DATA_W-1:0] wordOf(input int r, input int w);
    return DATA_W'(r * 64 + w);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Producer model: drive each requester's current word, valid and last marker.
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = active[i] && (numWords[i] == 0 || wordIdx[i] < numWords[i]);
      req_data[i*DATA_W +: DATA_W] = wordOf(i, wordIdx[i]);
      req_last[i] = (wordIdx[i] == lastAt[i]);
    end
  endtask

  task automatic applyStimulus(input int r, input logic act, input int nWords, input int lastIdx);
    active[r]   = act;
    numWords[r] = nWords;
    lastAt[r]   = lastIdx;
    drive();
  endtask

  task automatic pushExp(input int r, input int w);
    exp_t e;
    e.grant = NREQ'(1) << r;
    e.data  = wordOf(r, w);
    expQ.push_back(e);
  endtask

  // One clock: check any write before the edge, advance accepted words after it.
  task automatic cycle();
    logic [NREQ-1:0] accepted;
    exp_t e;
    #1;
    accepted = req_valid & req_ready;
    if (write_enable) begin
      checkOutput("wr_expected", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("wr_grant", 32'(grant), 32'(e.grant));
        checkOutput("wr_data", 32'(data_write), 32'(e.data));
      end
    end
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (accepted[i]) wordIdx[i]++;
    end
    drive();
    @(negedge wclk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_grant"}, 32'(grant), 32'd0);
    checkOutput({tag, "_we"}, 32'(write_enable), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'd0);
    checkOutput({tag, "_data"}, 32'(data_write), 32'd0);
  endtask

  task automatic resetDut();
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    expQ.delete();
    wrst_n    = 1'b0;
    wfull     = 1'b0;
    half_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      active[i]   = 1'b0;
      numWords[i] = 0;
      lastAt[i]   = -1;
      wordIdx[i]  = 0;
    end
    drive();
    #1;
    checkResetOutputs("reset");
    cycle();
    wrst_n = 1'b1;
  endtask

  // Directed scenarios in sequence.
  initial begin
    wrst_n    = 1'b0;
    wfull     = 1'b0;
    half_full = 1'b0;
    active    = '0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NREQ; i++) begin
      numWords[i] = 0;
      lastAt[i]   = -1;
      wordIdx[i]  = 0;
    end
    #2;
    checkResetOutputs("por");
    @(negedge wclk);
    resetDut();

    $display("[TB] single requester, 3-word burst with last");
    applyStimulus(2, 1'b1, 3, 2);
    for (int w = 0; w < 3; w++) pushExp(2, w);
    cycle();
    checkOutput("a_grant", 32'(grant), 32'h4);
    checkOutput("a_busy", 32'(busy), 32'd1);
    cycle();
    cycle();
    cycle();
    checkOutput("a_idle_grant", 32'(grant), 32'd0);
    checkOutput("a_idle_busy", 32'(busy), 32'd0);
    cycle();
    checkOutput("a_stay_idle", 32'(grant), 32'd0);

    $display("[TB] all requesters valid, rotation");
    resetDut();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b1, 0, -1);
    begin
      int order[5] = '{0, 1, 2, 3, 0};
      int base[NREQ] = '{0, 0, 0, 0};
      for (int g = 0; g < 5; g++) begin
        for (int b = 0; b < 4; b++) pushExp(order[g], base[order[g]] + b);
        base[order[g]] += 4;
        cycle();
        checkOutput("b_grant", 32'(grant), 32'(1 << order[g]));
        for (int b = 0; b < 4; b++) cycle();
        checkOutput("b_gap", 32'(grant), 32'd0);
      end
    end
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b0, 0, -1);
    cycle();
    checkOutput("b_off", 32'(grant), 32'd0);

    $display("[TB] half_full caps burst to one beat");
    resetDut();
    applyStimulus(1, 1'b1, 0, -1);
    for (int g = 0; g < 2; g++) begin
      half_full = 1'b1;
      pushExp(1, g);
      cycle();
      checkOutput("c_grant", 32'(grant), 32'h2);
      half_full = 1'b0;
      cycle();
      checkOutput("c_end", 32'(grant), 32'd0);
    end
    applyStimulus(1, 1'b0, 0, -1);
    cycle();

    $display("[TB] wfull stall mid-burst");
    resetDut();
    applyStimulus(0, 1'b1, 0, -1);
    for (int w = 0; w < 4; w++) pushExp(0, w);
    cycle();
    checkOutput("d_grant", 32'(grant), 32'h1);
    cycle();
    cycle();
    wfull = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      checkOutput("d_stall_ready", 32'(req_ready), 32'd0);
      checkOutput("d_stall_we", 32'(write_enable), 32'd0);
      checkOutput("d_stall_grant", 32'(grant), 32'h1);
      cycle();
    end
    wfull = 1'b0;
    cycle();
    cycle();
    applyStimulus(0, 1'b0, 0, -1);
    checkOutput("d_end", 32'(grant), 32'd0);
    cycle();
    checkOutput("d_stay_idle", 32'(grant), 32'd0);

    $display("[TB] reset mid-burst");
    resetDut();
    applyStimulus(3, 1'b1, 0, -1);
    pushExp(3, 0);
    pushExp(3, 1);
    cycle();
    checkOutput("e_grant", 32'(grant), 32'h8);
    cycle();
    cycle();
    applyStimulus(0, 1'b1, 0, -1);
    wrst_n = 1'b0;
    #1;
    checkResetOutputs("e_async");
    cycle();
    wrst_n = 1'b1;
    cycle();
    checkOutput("e_first_grant", 32'(grant), 32'h1);
    pushExp(0, 0);
    applyStimulus(3, 1'b0, 0, -1);
    cycle();
    applyStimulus(0, 1'b0, 0, -1);
    cycle();
    checkOutput("e_hold", 32'(grant), 32'h1);

    $display("[TB] granted requester drops valid");
    resetDut();
    applyStimulus(1, 1'b1, 0, -1);
    for (int w = 0; w < 4; w++) pushExp(1, w);
    cycle();
    checkOutput("f_grant", 32'(grant), 32'h2);
    cycle();
    applyStimulus(1, 1'b0, 0, -1);
    applyStimulus(0, 1'b1, 0, -1);
    applyStimulus(2, 1'b1, 0, -1);
    for (int s = 0; s < 6; s++) begin
      #1;
      checkOutput("f_hold_grant", 32'(grant), 32'h2);
      checkOutput("f_hold_we", 32'(write_enable), 32'd0);
      cycle();
    end
    applyStimulus(1, 1'b1, 0, -1);
    cycle();
    cycle();
    cycle();
    checkOutput("f_end", 32'(grant), 32'd0);
    cycle();
    checkOutput("f_next_grant", 32'(grant), 32'h4);
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b0, 0, -1);
    resetDut();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
